// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the programmable square-wave generator.
package freq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RUN
  } state_t;

  localparam int DIGITS  = 4;
  localparam int BCD_MAX = 9;

  // One spare bit so acc + 2*freq never overflows before the modulus compare.
  function automatic int acc_width(input int clk_hz);
    return $clog2(clk_hz) + 1;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq.sv
// Sequential 4-digit BCD to binary converter, one digit per clock, MSB digit first.
module bcd_to_binary_seq
  import freq_gen_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      bcd,
  output logic             busy,
  output logic             done,
  output logic             invalid,
  output logic [BIN_W-1:0] bin
);

  localparam logic [1:0] LAST_IDX = 2'(DIGITS - 1);
  localparam logic [3:0] MAX_DIG  = 4'(BCD_MAX);

  logic [15:0] digits;
  logic [1:0]  idx;
  logic [3:0]  digit;

  assign digit = digits[15:12];

  // done is a one-cycle strobe raised on the edge that consumes the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits  <= '0;
      idx     <= '0;
      bin     <= '0;
      invalid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        digits  <= bcd;
        idx     <= '0;
        bin     <= '0;
        invalid <= 1'b0;
        busy    <= 1'b1;
      end else if (busy) begin
        bin     <= bin * BIN_W'(10) + BIN_W'(digit);
        invalid <= invalid | (digit > MAX_DIG);
        digits  <= {digits[11:0], 4'h0};
        idx     <= idx + 2'd1;
        if (idx == LAST_IDX) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/frequency_generator.sv
// Phase-accumulator square-wave source driven by a BCD frequency request.
// Optional rising-edge strobe output Fx_Pulse when FREQ_GEN_PULSE_EN is defined.
module frequency_generator
  import freq_gen_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BIN_W  = 14,
  parameter int ACC_W  = acc_width(CLK_HZ)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [15:0]      Freq_BCD,
  input  logic             Load,
  output logic             Fxout,
  output logic             Busy,
  output logic             Err,
  output logic [BIN_W-1:0] Freq_Active
`ifdef FREQ_GEN_PULSE_EN
  ,
  output logic             Fx_Pulse
`endif
);

  localparam int CMP_W = ((ACC_W > BIN_W) ? ACC_W : BIN_W) + 1;
  localparam logic [ACC_W:0] ACC_MOD = (ACC_W + 1)'(CLK_HZ);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    sum;
  logic              wrap;
  logic              start;
  logic              too_fast;
  logic              conv_busy;
  logic              conv_done;
  logic              conv_invalid;
  logic [BIN_W-1:0]  conv_bin;

  bcd_to_binary_seq #(
    .BIN_W(BIN_W)
  ) u_conv (
    .clk    (Clk),
    .rst    (Rst),
    .start  (start),
    .bcd    (Freq_BCD),
    .busy   (conv_busy),
    .done   (conv_done),
    .invalid(conv_invalid),
    .bin    (conv_bin)
  );

  assign start    = Load && (state != CONV) && !conv_busy;
  assign sum      = {1'b0, acc} + (ACC_W + 1)'({Freq_Active, 1'b0});
  assign wrap     = (sum >= ACC_MOD);
  assign too_fast = CMP_W'({conv_bin, 1'b0}) > CMP_W'(CLK_HZ);

  // The accumulator keeps running through CONV; a commit overrides it below.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      acc         <= '0;
      Fxout       <= 1'b0;
      Busy        <= 1'b0;
      Err         <= 1'b0;
      Freq_Active <= '0;
`ifdef FREQ_GEN_PULSE_EN
      Fx_Pulse    <= 1'b0;
`endif
    end else begin
`ifdef FREQ_GEN_PULSE_EN
      Fx_Pulse <= 1'b0;
`endif
      if (Freq_Active != '0) begin
        if (wrap) begin
          acc   <= ACC_W'(sum - ACC_MOD);
          Fxout <= ~Fxout;
`ifdef FREQ_GEN_PULSE_EN
          Fx_Pulse <= ~Fxout;
`endif
        end else begin
          acc <= ACC_W'(sum);
        end
      end

      case (state)
        IDLE, RUN: begin
          if (start) begin
            state <= CONV;
            Busy  <= 1'b1;
          end
        end
        CONV: begin
          if (conv_done) begin
            Busy <= 1'b0;
            if (conv_invalid || too_fast) begin
              Err   <= 1'b1;
              state <= (Freq_Active != '0) ? RUN : IDLE;
            end else begin
              // Fxout holds its level on commit so the switch produces no runt pulse.
              Err         <= 1'b0;
              Freq_Active <= conv_bin;
              acc         <= '0;
`ifdef FREQ_GEN_PULSE_EN
              Fx_Pulse    <= 1'b0;
`endif
              if (conv_bin == '0) begin
                state <= IDLE;
                Fxout <= 1'b0;
              end else begin
                state <= RUN;
                Fxout <= Fxout;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench: random and directed requests against an arithmetic toggle-count model.
module tb_frequency_generator;

  localparam int CLK_HZ = 1000;
  localparam int BIN_W  = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [15:0]      freq_bcd;
  logic             fxout;
  logic             busy;
  logic             err;
  logic [BIN_W-1:0] freq_active;
`ifdef FREQ_GEN_PULSE_EN
  logic             fx_pulse;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model: level = base ^ parity(floor(k * 2f / CLK_HZ)), k = edges since commit.
  logic        m_busy;
  int          m_cyc;
  logic [15:0] m_bcd;
  logic        m_err;
  int          m_fa;
  longint      m_k;
  logic        m_base;
  logic        m_level;
  logic        m_pulse;

  logic last_fx;
  int   toggles;
  int   run_len;
  int   min_run;
  int   busy_rises;
  logic last_busy;

  always #5 clk = ~clk;

  frequency_generator #(
    .CLK_HZ(CLK_HZ),
    .BIN_W (BIN_W)
  ) dut (
    .Clk        (clk),
    .Rst        (rst),
    .Freq_BCD   (freq_bcd),
    .Load       (load),
    .Fxout      (fxout),
    .Busy       (busy),
    .Err        (err),
    .Freq_Active(freq_active)
`ifdef FREQ_GEN_PULSE_EN
    ,
    .Fx_Pulse   (fx_pulse)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_cyc   = 0;
    m_bcd   = '0;
    m_err   = 1'b0;
    m_fa    = 0;
    m_k     = 0;
    m_base  = 1'b0;
    m_level = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] bcd);
    logic prev;
    logic commit;
    logic bad;
    int   val;
    logic [3:0] d;
    prev   = m_level;
    commit = 1'b0;
    if (m_busy) begin
      m_cyc++;
      if (m_cyc == 5) begin
        m_busy = 1'b0;
        bad = 1'b0;
        val = 0;
        for (int i = 3; i >= 0; i--) begin
          d = m_bcd[i*4 +: 4];
          if (d > 4'd9) bad = 1'b1;
          val = val * 10 + int'(d);
        end
        if (bad || (2 * val > CLK_HZ)) begin
          m_err = 1'b1;
        end else begin
          m_err  = 1'b0;
          m_fa   = val;
          m_k    = 0;
          m_base = (val == 0) ? 1'b0 : prev;
          commit = 1'b1;
        end
      end
    end else if (ld) begin
      m_busy = 1'b1;
      m_cyc  = 0;
      m_bcd  = bcd;
    end
    if (!commit && m_fa != 0) m_k++;
    if (m_fa == 0) m_level = m_base;
    else m_level = m_base ^ (((m_k * 2 * m_fa / CLK_HZ) % 2) == 1);
    m_pulse = !prev && m_level;
  endtask

  task automatic apply_stimulus(input logic ld, input logic [15:0] bcd);
    @(negedge clk);
    load     = ld;
    freq_bcd = bcd;
    @(posedge clk);
    model_edge(ld, bcd);
    #1;
    check_output("fxout", 32'(fxout), 32'(m_level));
    check_output("busy", 32'(busy), 32'(m_busy));
    check_output("err", 32'(err), 32'(m_err));
    check_output("freq_active", 32'(freq_active), 32'(m_fa));
`ifdef FREQ_GEN_PULSE_EN
    check_output("fx_pulse", 32'(fx_pulse), 32'(m_pulse));
`endif
    if (fxout != last_fx) begin
      toggles++;
      if (run_len < min_run) min_run = run_len;
      run_len = 1;
      last_fx = fxout;
    end else begin
      run_len++;
    end
    if (busy && !last_busy) busy_rises++;
    last_busy = busy;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 16'h0000);
  endtask

  task automatic check_reset_values(input string phase);
    check_output({phase, "_fxout"}, 32'(fxout), 32'd0);
    check_output({phase, "_busy"}, 32'(busy), 32'd0);
    check_output({phase, "_err"}, 32'(err), 32'd0);
    check_output({phase, "_freq_active"}, 32'(freq_active), 32'd0);
  endtask

  initial begin
    int mode;
    int val;
    logic [15:0] req;

    rst      = 1'b1;
    load     = 1'b0;
    freq_bcd = '0;
    model_reset();
    last_fx    = 1'b0;
    last_busy  = 1'b0;
    toggles    = 0;
    run_len    = 0;
    min_run    = 1000000;
    busy_rises = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] 100 Hz request");
    apply_stimulus(1'b1, 16'h0100);
    idle_cycles(4);
    check_output("busy_before_commit", 32'(busy), 32'd1);
    idle_cycles(1);
    check_output("fa_100_at_n5", 32'(freq_active), 32'd100);
    check_output("busy_after_commit", 32'(busy), 32'd0);
    toggles = 0;
    idle_cycles(40);
    check_output("toggles_100_in_40", 32'(toggles), 32'd8);

    $display("[TB] invalid digit while running");
    apply_stimulus(1'b1, 16'h0A12);
    idle_cycles(5);
    check_output("err_bad_digit", 32'(err), 32'd1);
    check_output("fa_kept_100", 32'(freq_active), 32'd100);
    idle_cycles(20);

    $display("[TB] out of range then retune to 250");
    apply_stimulus(1'b1, 16'h0600);
    idle_cycles(5);
    check_output("err_too_fast", 32'(err), 32'd1);
    min_run = 1000000;
    apply_stimulus(1'b1, 16'h0250);
    idle_cycles(5);
    check_output("err_cleared", 32'(err), 32'd0);
    check_output("fa_250", 32'(freq_active), 32'd250);
    idle_cycles(30);
    check_output("min_run_at_switch", 32'(min_run >= 2), 32'd1);

    $display("[TB] 3 Hz window");
    apply_stimulus(1'b1, 16'h0003);
    idle_cycles(5);
    check_output("fa_3", 32'(freq_active), 32'd3);
    toggles = 0;
    idle_cycles(1000);
    check_output("toggles_3_in_1000", 32'(toggles), 32'd6);

    $display("[TB] zero request with ignored second load");
    busy_rises = 0;
    apply_stimulus(1'b1, 16'h0000);
    apply_stimulus(1'b0, 16'h0000);
    apply_stimulus(1'b1, 16'h0500);
    idle_cycles(8);
    check_output("single_commit", 32'(busy_rises), 32'd1);
    check_output("fa_zero", 32'(freq_active), 32'd0);
    toggles = 0;
    idle_cycles(20);
    check_output("fxout_held_zero", 32'(toggles + int'(fxout)), 32'd0);

    $display("[TB] asynchronous reset mid-run");
    apply_stimulus(1'b1, 16'h0100);
    idle_cycles(12);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("async");
    model_reset();
    last_fx   = 1'b0;
    last_busy = 1'b0;
    run_len   = 0;
    #1;
    rst = 1'b0;
    idle_cycles(3);

    $display("[TB] randomized requests");
    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       begin val = int'($urandom_range(1, 500));  req = to_bcd(val); end
        1:       begin val = int'($urandom_range(0, 9999)); req = to_bcd(val); end
        2:       req = 16'($urandom);
        default: req = 16'h0000;
      endcase
      apply_stimulus(1'b1, req);
      idle_cycles(int'($urandom_range(0, 12)));
    end
    idle_cycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frequency_generator.md
Name: frequency_generator

Overview:
- Programmable square-wave source; the stimulus counterpart to the frequency meter.
- Accepts a 4-digit BCD frequency in Hz, converts it sequentially to binary and drives Fxout at exactly that average frequency.
- Uses a modulo-CLK_HZ phase accumulator, so no divider is needed.
- Fxout can loop back into the meter's Fxin for self-test.

Parameters:
- CLK_HZ, 100_000_000, frequency of Clk in Hz; also the accumulator modulus.
- BIN_W, 14, width of the binary frequency (holds 0..9999).
- ACC_W, $clog2(CLK_HZ)+1, accumulator width; derived, not to be overridden.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Freq_BCD  in  16  requested frequency, 4 BCD digits, [15:12] = thousands.
- Load  in  1  one-cycle request strobe; Freq_BCD is sampled on the same edge.
- Fxout  out  1  generated square wave.
- Busy  out  1  high while a conversion is in progress.
- Err  out  1  last request rejected.
- Freq_Active  out  BIN_W  binary frequency currently being generated.

Behaviour:
- Reset (asynchronous, Rst=1): state IDLE; Fxout=0, Busy=0, Err=0, Freq_Active=0, accumulator=0, conversion registers=0.
- States:
  - IDLE: no frequency loaded.
  - CONV: 4 cycles, one digit per cycle, MSB digit first; bin <= bin*10 + digit.
  - RUN: generating.
- Request acceptance: Load=1 sampled at edge n in IDLE or RUN:
  - Freq_BCD is latched and the state goes to CONV.
  - Busy=1 from edge n to edge n+5.
  - Digits are processed on edges n+1..n+4.
  - The result is checked and committed or rejected at edge n+5.
- Load during CONV is ignored; Freq_BCD is not re-sampled.
- RUN continues with the old Freq_Active during CONV; output is uninterrupted.
- Rejection: any digit > 9, or 2*bin > CLK_HZ.
  - Err=1; Freq_Active and the accumulator are unchanged.
  - Return to the prior state: RUN if Freq_Active != 0, else IDLE.
- Commit:
  - Freq_Active <= bin; Err=0; accumulator <= 0; Fxout is left unchanged, so there is no runt pulse.
  - Next state RUN if bin != 0, else IDLE.
- Frequency 0: state IDLE, Fxout forced to 0 on the commit edge, accumulator held at 0.
- RUN, every cycle: sum = acc + 2*Freq_Active.
  - If sum >= CLK_HZ: acc <= sum - CLK_HZ and Fxout toggles.
  - Otherwise acc <= sum.
  - This gives at most one toggle per cycle and an exact long-term average of Freq_Active Hz.
  - Compute sum in ACC_W+1 bits; there is no wrap.
- Err remains 1 until the next successful commit.
- Reset mid-CONV or mid-RUN: all state is lost immediately and the block returns to the reset values.

Optional Feature:
- Macro: FREQ_GEN_PULSE_EN.
- Defined:
  - Adds output port Fx_Pulse, 1 bit, reset 0.
  - Fx_Pulse is high for exactly one Clk cycle after each 0->1 toggle of Fxout, aligned to the same edge.
  - Intended as a synchronous rising-edge strobe for on-chip consumers.
- Not defined: the port is absent and there is no extra logic.

Decomposition:
- Package freq_gen_pkg holds:
  - the state enum {IDLE, CONV, RUN};
  - DIGITS=4, BCD_MAX=9;
  - a function computing ACC_W from CLK_HZ.
- Sub-module bcd_to_binary_seq:
  - start/busy/done handshake;
  - 4-cycle multiply-by-10-and-add datapath;
  - invalid-digit flag output.
- The top level owns the FSM, range check, accumulator and Fxout.

Test Plan (CLK_HZ=1000 override):
- Rst pulse asserted mid-cycle -> all outputs 0 immediately (asynchronous), before the next Clk edge.
- Load with Freq_BCD=16'h0100 -> Busy high 5 cycles, Freq_Active=100 at edge n+5, Fxout toggles every 5 cycles (period 10), Err=0.
- Load with 16'h0003 -> exactly 6 Fxout toggles in any 1000-cycle window after commit; Freq_Active=3.
- While running 100, Load with 16'h0A12 -> Err=1, Freq_Active stays 100, Fxout continues with period 10, no gap.
- While running, Load with 16'h0600 (2*600 > 1000) -> Err=1, no change; then Load with 16'h0250 -> Err=0, period 4, no output pulse shorter than 2 cycles at the switch.
- Load with 16'h0000 -> IDLE, Fxout=0 held; second Load asserted during CONV -> ignored, exactly one commit.
